// File: rtl/prog_loader_if.sv
// Word-stream handshake between a program source (UART/JTAG word
// assembler) and the prog_loader sequencer. A word moves on every rising
// edge where in_valid and in_ready are both high.
interface prog_loader_if;
    logic        in_valid;
    logic [11:0] in_data;
    logic        in_ready;

    // Word source side
    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    // Loader side
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/prog_loader.sv
// Program-load sequencer for the SAP-2 mini 256x12 RAM.
// Streams words from the source interface into consecutive RAM addresses
// through the prog/a/d/we programming port, holding the CPU in clear for
// the whole session and releasing it once the last word is written.
//
// Optional feature: define PROG_LOADER_CKSUM_EN to add a trailing checksum
// word and the CHECK state. The whole stream (data plus checksum) must sum
// to 0 mod 4096, otherwise err is raised and held until the next start.
// Without the macro err is tied low.
//
// Control outputs are decoded from the state register only, so there is
// no combinational path from in_valid to in_ready. a and d hold their last
// value between sessions; clr_n clears them.
module prog_loader (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    input  logic [7:0]   base,
    input  logic [7:0]   len,
    prog_loader_if.slave src,
    output logic         prog,
    output logic [7:0]   a,
    output logic [11:0]  d,
    output logic         we,
    output logic         cpu_clr,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        WAIT    = 3'd2,
        WRITE   = 3'd3,
        RELEASE = 3'd4
`ifdef PROG_LOADER_CKSUM_EN
        ,
        CHECK   = 3'd5
`endif
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [8:0]  count_q;
    logic        rdy;
    logic        last_word;

`ifdef PROG_LOADER_CKSUM_EN
    logic [11:0] cksum_q;
    logic        err_q;

    // Checksum arithmetic wraps modulo 4096 (12-bit word width).
    function automatic logic [11:0] cksum_add(input logic [11:0] acc, input logic [11:0] w);
        cksum_add = acc + w;
    endfunction
`endif

    assign last_word    = (count_q == 9'd1);
    assign src.in_ready = rdy;

    // State register; clr_n aborts any session back to IDLE.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded control outputs.
    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        prog    = 1'b0;
        cpu_clr = 1'b0;
        we      = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                prog    = 1'b1;
                cpu_clr = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                prog    = 1'b1;
                cpu_clr = 1'b1;
                rdy     = 1'b1;
                if (src.in_valid) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                prog    = 1'b1;
                cpu_clr = 1'b1;
                we      = 1'b1;
                if (last_word) begin
`ifdef PROG_LOADER_CKSUM_EN
                    state_d = CHECK;
`else
                    state_d = RELEASE;
`endif
                end else begin
                    state_d = WAIT;
                end
            end
`ifdef PROG_LOADER_CKSUM_EN
            CHECK: begin
                prog    = 1'b1;
                cpu_clr = 1'b1;
                rdy     = 1'b1;
                if (src.in_valid) begin
                    state_d = RELEASE;
                end
            end
`endif
            RELEASE: begin
                cpu_clr = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Session datapath: address/data/count latches and checksum tracking.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            a       <= 8'h00;
            d       <= 12'h000;
            count_q <= 9'd0;
`ifdef PROG_LOADER_CKSUM_EN
            cksum_q <= 12'h000;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a       <= base;
                        count_q <= {(len == 8'd0), len};
`ifdef PROG_LOADER_CKSUM_EN
                        cksum_q <= 12'h000;
                        err_q   <= 1'b0;
`endif
                    end
                end
                WAIT: begin
                    if (src.in_valid) begin
                        d <= src.in_data;
`ifdef PROG_LOADER_CKSUM_EN
                        cksum_q <= cksum_add(cksum_q, src.in_data);
`endif
                    end
                end
                WRITE: begin
                    a       <= a + 8'd1;
                    count_q <= count_q - 9'd1;
                end
`ifdef PROG_LOADER_CKSUM_EN
                CHECK: begin
                    if (src.in_valid && (cksum_add(cksum_q, src.in_data) != 12'h000)) begin
                        err_q <= 1'b1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifdef PROG_LOADER_CKSUM_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of load sessions plus
// hand-written sequences for mid-session start, clr_n abort and checksum.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  base = 8'h00;
    logic [7:0]  len = 8'h00;
    logic        prog, we, cpu_clr, busy, done, err;
    logic [7:0]  a;
    logic [11:0] d;

    prog_loader_if bus ();

    prog_loader dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .start   (start),
        .base    (base),
        .len     (len),
        .src     (bus),
        .prog    (prog),
        .a       (a),
        .d       (d),
        .we      (we),
        .cpu_clr (cpu_clr),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // RAM model and event counters, sampled mid-cycle
    logic [11:0] ram [0:255];
    int   we_cnt = 0;
    int   done_cnt = 0;
    int   viol = 0;
    logic prev_we = 1'b0;

    always @(negedge clk) begin
        if (we) begin
            ram[a] <= d;
            we_cnt <= we_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if ((cpu_clr !== busy) || (prog !== (busy & ~done)) || (we & prev_we) || (we & bus.in_ready))
            viol <= viol + 1;
        prev_we <= we;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired, got no event, want event", name);
    endtask

    typedef struct {
        logic [7:0]  base;
        logic [7:0]  len;
        logic [11:0] w0;
        logic [11:0] step;
        int          gap;
        logic        mid;
        int          exp_we;
        logic [7:0]  exp_a;
    } vec_t;

    vec_t vecs [7];

    // Pulse start, then check SETUP and WAIT decoding. Ends at posedge+1.
    task automatic start_session(input logic [7:0] b, input logic [7:0] l);
        @(posedge clk); #1;
        start = 1'b1; base = b; len = l;
        @(posedge clk); #1;
        start = 1'b0; base = 8'h5A; len = 8'h33;
        @(negedge clk); #1;
        chk("setup_ctl", 32'({prog, cpu_clr, busy, bus.in_ready, we, done}), 32'b111000);
        chk("setup_err", 32'(err), 32'd0);
        @(negedge clk); #1;
        chk("wait_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    // Offer one word after gap idle cycles; returns at posedge+1 after the handshake.
    task automatic feed_word(input logic [11:0] w, input int gap, input logic mid);
        bit   ok;
        logic r;
        ok = 1'b0;
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 12'hEEE;
            repeat (gap) begin @(posedge clk); #1; end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk); #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 12'hEEE;
        if (!ok) timeout_fail("handshake");
        if (mid) begin
            start = 1'b1; base = 8'h80; len = 8'h07;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    // Wait for done and check the session epilogue.
    task automatic finish_session(input int exp_we, input logic [7:0] exp_a, input logic exp_err,
                                  input int we0, input int done0);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("done_wait");
        chk("done_a", 32'(a), 32'(exp_a));
        chk("done_err", 32'(err), 32'(exp_err));
        chk("done_ctl", 32'({cpu_clr, prog}), 32'b10);
        @(negedge clk); #1;
        chk("post_ctl", 32'({cpu_clr, busy, done, prog, we}), 32'd0);
        chk("post_err", 32'(err), 32'(exp_err));
        chk("we_count", 32'(we_cnt - we0), 32'(exp_we));
        chk("done_count", 32'(done_cnt - done0), 32'd1);
        chk("ctl_rules", 32'(viol), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v);
        int          n, we0, done0, bad;
        logic [11:0] w, sum;
        logic [7:0]  ad;
        n     = (v.len == 8'd0) ? 256 : int'(v.len);
        we0   = we_cnt;
        done0 = done_cnt;
        sum   = 12'h000;
        start_session(v.base, v.len);
        for (int k = 0; k < n; k++) begin
            w   = v.w0 + v.step * 12'(k);
            sum = sum + w;
            feed_word(w, v.gap, (k == 0) && v.mid);
        end
`ifdef PROG_LOADER_CKSUM_EN
        feed_word(12'h000 - sum, v.gap, 1'b0);
`endif
        finish_session(v.exp_we, v.exp_a, 1'b0, we0, done0);
        bad = 0;
        for (int k = 0; k < n; k++) begin
            w  = v.w0 + v.step * 12'(k);
            ad = v.base + 8'(k);
            if (ram[ad] !== w) begin
                if (bad == 0)
                    $display("FAIL ram_image: RAM[0x%0h] got 0x%0h, want 0x%0h", ad, ram[ad], w);
                bad++;
            end
        end
        n_cmp++;
        if (bad != 0) n_bad++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, want summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0, done0;
        // base, len, w0, step, gap, mid-start, expected we pulses, expected final a
        vecs[0] = '{8'h10, 8'd3, 12'h0A1, 12'h111, 0, 1'b0, 3,   8'h13};
        vecs[1] = '{8'hF0, 8'd0, 12'h000, 12'h001, 0, 1'b0, 256, 8'hF0};
        vecs[2] = '{8'h40, 8'd2, 12'h555, 12'h111, 3, 1'b0, 2,   8'h42};
        vecs[3] = '{8'h60, 8'd2, 12'h7E0, 12'h00F, 7, 1'b0, 2,   8'h62};
        vecs[4] = '{8'h20, 8'd3, 12'h321, 12'h101, 0, 1'b1, 3,   8'h23};
        vecs[5] = '{8'hFF, 8'd1, 12'hABC, 12'h000, 1, 1'b0, 1,   8'h00};
        vecs[6] = '{8'h50, 8'd2, 12'h0F0, 12'h00F, 1, 1'b0, 2,   8'h52};

        bus.in_valid = 1'b0;
        bus.in_data  = 12'h000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", 32'({bus.in_ready, prog, we, cpu_clr, busy, done, err}), 32'd0);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        clr_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("idle_no_start", 32'({busy, cpu_clr, prog}), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // clr_n abort after 2 of 5 words
        we0 = we_cnt;
        start_session(8'h30, 8'd5);
        feed_word(12'h111, 0, 1'b0);
        feed_word(12'h222, 0, 1'b0);
        @(negedge clk); #1;
        #2;
        clr_n = 1'b0;
        #1;
        chk("abort_ctl", 32'({bus.in_ready, prog, we, cpu_clr, busy, done, err}), 32'd0);
        chk("abort_ad", 32'({a, d}), 32'd0);
        chk("abort_we_count", 32'(we_cnt - we0), 32'd2);
        chk("abort_ram", 32'({ram[8'h30], ram[8'h31]}), 32'h111222);
        @(posedge clk); #1;
        clr_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_idle", 32'({busy, cpu_clr, prog}), 32'd0);
        run_vec(vecs[6]);

`ifdef PROG_LOADER_CKSUM_EN
        // Good checksum, bad checksum, then err clears on next start
        we0 = we_cnt; done0 = done_cnt;
        start_session(8'h00, 8'd2);
        feed_word(12'h100, 0, 1'b0);
        feed_word(12'h200, 0, 1'b0);
        feed_word(12'hD00, 0, 1'b0);
        finish_session(2, 8'h02, 1'b0, we0, done0);
        chk("ck_ram", 32'({ram[8'h00], ram[8'h01]}), 32'h100200);
        we0 = we_cnt; done0 = done_cnt;
        start_session(8'h00, 8'd2);
        feed_word(12'h100, 0, 1'b0);
        feed_word(12'h200, 0, 1'b0);
        feed_word(12'hD01, 0, 1'b0);
        finish_session(2, 8'h02, 1'b1, we0, done0);
        repeat (2) begin @(posedge clk); #1; end
        chk("err_sticky", 32'(err), 32'd1);
        we0 = we_cnt; done0 = done_cnt;
        start_session(8'h04, 8'd1);
        feed_word(12'h00F, 0, 1'b0);
        feed_word(12'hFF1, 0, 1'b0);
        finish_session(1, 8'h05, 1'b0, we0, done0);
        chk("ck_ram2", 32'(ram[8'h04]), 32'h00F);
`else
        we0 = we_cnt; done0 = done_cnt;
        start_session(8'h00, 8'd2);
        feed_word(12'h100, 0, 1'b0);
        feed_word(12'h200, 0, 1'b0);
        finish_session(2, 8'h02, 1'b0, we0, done0);
        chk("plain_ram", 32'({ram[8'h00], ram[8'h01]}), 32'h100200);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
